// File: rtl/pixel_writeback.sv
// Write-back stage for the 3x3 kernel path: hands out raster pixel indices,
// accepts one signed kernel result per pixel, normalises and clamps it to an
// unsigned pixel, and writes it to the output frame RAM one cycle later.
module pixel_writeback #(
  parameter int N      = 256,
  parameter int DATA_W = 17,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 16,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] pixel_index,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N * N - 1);

  state_t state;
  state_t state_nxt;

  logic signed [DATA_W-1:0] in_data_s;
  logic                     accept;

  logic                     vld_p1;
  logic        [ADDR_W-1:0] wr_addr_p1;
  logic        [PIX_W-1:0]  wr_data_p1;

  // Normalise by SHIFT, then clamp to [0, 2**PIX_W-1] at full input width so
  // large magnitudes cannot alias into the pixel range.
  function automatic logic [PIX_W-1:0] sat_pix(input logic signed [DATA_W-1:0] d);
    logic signed [DATA_W-1:0] v;
    logic signed [DATA_W-1:0] pmax;
    pmax = DATA_W'((2 ** PIX_W) - 1);
    v    = d >>> SHIFT;
    if (v < 0)
      sat_pix = '0;
    else if (v > pmax)
      sat_pix = '1;
    else
      sat_pix = v[PIX_W-1:0];
  endfunction

  assign in_data_s = $signed(in_data);
  assign accept    = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and handshake/status decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start)
          state_nxt = S_RUN;
      end
      S_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (pixel_index == LAST_IDX))
          state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Raster index: cleared on frame start, advanced per accept, parks on the
  // last pixel until the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pixel_index <= '0;
    else if ((state == S_IDLE) && start)
      pixel_index <= '0;
    else if (accept && (pixel_index != LAST_IDX))
      pixel_index <= pixel_index + 1'b1;
  end

  // ---- stage p0 -> p1: accepted result becomes a RAM write ----
  // Write port register; address/data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        wr_addr_p1 <= pixel_index;
        wr_data_p1 <= sat_pix(in_data_s);
      end
    end
  end

  assign wr_en   = vld_p1;
  assign wr_addr = wr_addr_p1;
  assign wr_data = wr_data_p1;

endmodule

// File: tb/tb_pixel_writeback.sv
// Bench for pixel_writeback (N=4): two instances share stimulus, one with
// SHIFT=0 and one with SHIFT=4. Expected writes are queued at accept time and
// a monitor compares them against the RAM write port.
module tb_pixel_writeback;

  localparam int N      = 4;
  localparam int DATA_W = 17;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 4;
  localparam int NPIX   = N * N;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;

  logic              in_ready, wr_en, busy, done;
  logic [ADDR_W-1:0] pixel_index, wr_addr;
  logic [PIX_W-1:0]  wr_data;

  logic              in_ready4, wr_en4, busy4, done4;
  logic [ADDR_W-1:0] pixel_index4, wr_addr4;
  logic [PIX_W-1:0]  wr_data4;

  pixel_writeback #(.N(N), .DATA_W(DATA_W), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pixel_index(pixel_index), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  pixel_writeback #(.N(N), .DATA_W(DATA_W), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .SHIFT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready4), .pixel_index(pixel_index4), .wr_en(wr_en4), .wr_addr(wr_addr4),
    .wr_data(wr_data4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int d0;
    int d4;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;
  int expected_writes = 0;
  int writes_seen = 0;
  int done_seen = 0;
  int frames_done = 0;
  int last_addr = 0;
  int last_d0 = 0;
  int last_d4 = 0;

  int tbl[8] = '{-5, 255, 256, 65535, 4080, -16, 0, -65536};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp)
      passes++;
    else
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: divide by 2**sh rounding toward -inf, then clamp to 0..255.
  function automatic int ref_sat(input int x, input int sh);
    int v;
    v = x >>> sh;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int pick(input int mode, input int idx);
    if (mode == 0) return idx * 10;
    if (mode == 2) return tbl[idx % 8];
    if ($urandom_range(0, 3) == 0) return tbl[$urandom_range(0, 7)];
    return int'($urandom_range(0, 131071)) - 65536;
  endfunction

  // Monitor: every write must match the next queued expectation; between
  // writes the port must hold the last written address/data.
  always @(negedge clk) begin
    exp_t e;
    if (wr_en) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        chk("spurious_wr_en", int'(wr_en), 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(wr_addr), e.addr);
        chk("wr_data", int'(wr_data), e.d0);
        chk("wr_en_shift4", int'(wr_en4), 1);
        chk("wr_addr_shift4", int'(wr_addr4), e.addr);
        chk("wr_data_shift4", int'(wr_data4), e.d4);
        last_addr = e.addr;
        last_d0   = e.d0;
        last_d4   = e.d4;
      end
    end else begin
      chk("wr_addr_hold", int'(wr_addr), last_addr);
      chk("wr_data_hold", int'(wr_data), last_d0);
      chk("wr_data_hold_shift4", int'(wr_data4), last_d4);
    end
    if (done) done_seen++;
  end

  // One frame starting from IDLE at a negedge; returns at the negedge in DONE.
  task automatic frame(input int gap_pct, input int mode, input int start_at);
    int idx;
    int x;
    bit v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    while (idx < NPIX) begin
      chk("pixel_index", int'(pixel_index), idx);
      chk("pixel_index_shift4", int'(pixel_index4), idx);
      chk("in_ready_run", int'(in_ready), 1);
      chk("busy_run", int'(busy), 1);
      chk("done_run", int'(done), 0);
      v = ($urandom_range(0, 99) >= gap_pct);
      x = pick(mode, idx);
      in_valid = v;
      in_data  = DATA_W'(x);
      start    = (idx == start_at);
      if (v) begin
        exp_q.push_back('{addr: idx, d0: ref_sat(x, 0), d4: ref_sat(x, 4)});
        expected_writes++;
        idx++;
      end
      @(negedge clk);
    end
    // Flush cycle: last write on the bus, no more accepts.
    in_valid = 1'($urandom_range(0, 1));
    in_data  = DATA_W'(pick(1, 0));
    start    = 1'b0;
    chk("in_ready_flush", int'(in_ready), 0);
    chk("in_ready_flush_shift4", int'(in_ready4), 0);
    chk("busy_flush", int'(busy), 1);
    chk("done_flush", int'(done), 0);
    @(negedge clk);
    chk("done_pulse", int'(done), 1);
    chk("done_pulse_shift4", int'(done4), 1);
    chk("busy_done", int'(busy), 0);
    chk("busy_done_shift4", int'(busy4), 0);
    chk("in_ready_done", int'(in_ready), 0);
    frames_done++;
  endtask

  task automatic idle_step();
    @(negedge clk);
    chk("done_idle", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
    chk("pixel_index_park", int'(pixel_index), NPIX - 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;

    // Reset and idle behaviour: in_valid without start must do nothing.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pixel_index", int'(pixel_index), 0);
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = DATA_W'(pick(1, i));
      @(negedge clk);
      chk("idle_in_ready", int'(in_ready), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_pixel_index", int'(pixel_index), 0);
    end
    in_valid = 1'b0;

    // Ramp frame, continuous valid.
    frame(0, 0, -1);
    idle_step();
    // Saturation corner values, continuous valid.
    frame(0, 2, -1);
    idle_step();
    // Random gaps, stray start mid-frame; next frame back-to-back from IDLE.
    frame(40, 1, 5);
    idle_step();
    frame(25, 1, -1);

    // Mid-frame reset after index 7 is accepted.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int x;
      chk("pre_rst_pixel_index", int'(pixel_index), i);
      x = pick(1, i);
      in_valid = 1'b1;
      in_data  = DATA_W'(x);
      exp_q.push_back('{addr: i, d0: ref_sat(x, 0), d4: ref_sat(x, 4)});
      expected_writes++;
      if (i < 7) @(negedge clk);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    expected_writes -= exp_q.size();
    exp_q.delete();
    last_addr = 0;
    last_d0 = 0;
    last_d4 = 0;
    #1;
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_wr_addr", int'(wr_addr), 0);
    chk("midrst_wr_data", int'(wr_data), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pixel_index", int'(pixel_index), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    frame(30, 1, -1);
    idle_step();

    repeat (3) @(negedge clk);
    chk("write_count", writes_seen, expected_writes);
    chk("done_count", done_seen, frames_done);
    chk("pending_expectations", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pixel_writeback.md
Name: pixel_writeback

Overview:
Write-side counterpart to the 3x3 kernel fetch stage. It issues the current pixel index to the fetch/convolution path and accepts one kernel result per pixel through a valid/ready handshake. Each result is normalised and saturated to an 8-bit pixel, then written to the output frame RAM at the matching raster address. It sequences one full NxN frame per start command.

Parameters:
N, 256, image width/height in pixels (frame = N*N pixels, raster order)
DATA_W, 17, width of incoming kernel result (two's complement)
PIX_W, 8, width of written pixel
ADDR_W, 16, output RAM address width (must satisfy 2**ADDR_W >= N*N)
SHIFT, 0, arithmetic right shift applied before saturation (e.g. 4 for a /16 kernel)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a frame; sampled only in IDLE
in_valid  in  1  in_data holds the result for pixel_index
in_data  in  DATA_W  kernel result, signed two's complement
in_ready  out  1  block can accept a result this cycle
pixel_index  out  ADDR_W  raster index of the pixel currently expected; drives the fetch stage's i input
wr_en  out  1  output RAM write strobe, one cycle per pixel
wr_addr  out  ADDR_W  output RAM write address
wr_data  out  PIX_W  saturated pixel value
busy  out  1  high in RUN and FLUSH
done  out  1  single-cycle pulse when the last pixel of a frame has been written

Behaviour:
- Reset (async, rst=1): state=IDLE; pixel_index=0; in_ready=0; wr_en=0; wr_addr=0; wr_data=0; busy=0; done=0. An in-flight write is dropped. A partially written frame is not resumed.
- States:
  - IDLE: in_ready=0; in_valid is ignored. If start=1: pixel_index<=0 and go to RUN.
  - RUN: in_ready=1. On accept (in_valid & in_ready):
    - capture index = pixel_index.
    - If index == N*N-1, go to FLUSH; otherwise pixel_index<=pixel_index+1.
    - No accept: hold pixel_index, wr_en=0 next cycle.
  - FLUSH: in_ready=0; the last write is on the bus this cycle. Next state is DONE.
  - DONE: done=1 for exactly this cycle; busy=0; next state is IDLE. pixel_index stays at N*N-1 until the next start.
- start while not IDLE: ignored. Back-to-back frames: start asserted in the cycle after DONE, i.e. in IDLE, is accepted.
- Write path:
  - Registered, latency 1 cycle. The accept at edge k drives wr_en=1, wr_addr=captured index and wr_data=sat(in_data) during cycle k+1. Otherwise wr_en=0.
  - wr_addr and wr_data hold their last values when wr_en=0.
  - Throughput is 1 pixel per cycle when in_valid is held high.
- Arithmetic:
  - v = in_data >>> SHIFT (sign-preserving).
  - If v<0, wr_data=0. If v>2**PIX_W-1, wr_data=2**PIX_W-1. Otherwise wr_data=v[PIX_W-1:0].
  - The comparison is done at full DATA_W width; no truncation before clamping.
- pixel_index never exceeds N*N-1; no wrap-around within a frame.
- Exactly N*N wr_en pulses occur per frame. No address is written twice, and none is skipped.
- busy=1 from the cycle after start is accepted through FLUSH inclusive.

Test Plan:
- Reset/idle, N=4: hold rst, then release, then drive in_valid=1 without start for 10 cycles -> all outputs 0, in_ready=0, no wr_en.
- Full frame, N=4, SHIFT=0, in_valid always 1, in_data=index*10 -> 16 wr_en pulses, addresses 0..15 in order. wr_data = 0,10,...,150 for indices 0..15. done pulses once, 2 cycles after the last accept. busy drops with done.
- Saturation, SHIFT=0: in_data = -5 (17'h1FFFB), 255, 256, 65535 (17'h0FFFF) -> wr_data = 0, 255, 255, 255. SHIFT=4 with in_data=4080 -> 255; with -16 -> 0.
- Handshake gaps, N=4: toggle in_valid pseudo-randomly -> pixel_index advances only on accepts. wr_addr sequence stays 0..15 with no repeats. wr_en count = 16.
- Mid-frame reset: assert rst after index 7 is accepted -> outputs 0 immediately and the pending write is dropped. A following start rewrites from address 0, and done occurs only after index 15.
- start during RUN, and back-to-back frames: start pulsed at index 5 -> ignored, frame completes normally. start in the cycle after done -> second frame writes 0..15 again.
